// File: rtl/fft_pkg.sv
// Shared types and sizing for the FFT frame sequencer and its output tracker.
package fft_pkg;

  localparam int N_POINT       = 512;
  localparam int LANES         = 16;
  localparam int BLK_PER_FRAME = N_POINT / LANES;
  localparam int MAX_INFLIGHT  = 2;
  localparam int INFLIGHT_W    = $clog2(MAX_INFLIGHT + 1);

  typedef logic [4:0] blk_idx_t;
  typedef logic [INFLIGHT_W-1:0] inflight_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } frame_state_e;

  localparam blk_idx_t  LAST_BLK     = blk_idx_t'(BLK_PER_FRAME - 1);
  localparam inflight_t INFLIGHT_MAX = inflight_t'(MAX_INFLIGHT);

  function automatic blk_idx_t next_idx(input blk_idx_t idx);
    return (idx == LAST_BLK) ? blk_idx_t'(0) : blk_idx_t'(idx + 5'd1);
  endfunction

endpackage

// File: rtl/fft_out_tracker.sv
// Follows blocks returning from the pipeline: block index, frame start/end tags
// and the end-of-frame pulse that retires a frame in flight.
module fft_out_tracker
  import fft_pkg::*;
(
  input  logic     clk,
  input  logic     rstn,
  input  logic     pipe_out_valid,
  input  logic     inflight_zero,
  output blk_idx_t out_blk_idx,
  output logic     out_sof,
  output logic     out_eof,
  output logic     eof_pulse,
  output logic     frame_done
);

  logic advance;

  // Returns with nothing in flight are spurious and must not move the index.
  assign advance   = pipe_out_valid && !inflight_zero;
  assign out_sof   = pipe_out_valid && (out_blk_idx == blk_idx_t'(0));
  assign out_eof   = pipe_out_valid && (out_blk_idx == LAST_BLK);
  assign eof_pulse = out_eof && !inflight_zero;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_blk_idx <= '0;
      frame_done  <= 1'b0;
    end else begin
      if (advance) begin
        out_blk_idx <= next_idx(out_blk_idx);
      end
      frame_done <= eof_pulse;
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer: gates 16-sample blocks into the FFT pipeline as 32-block
// frames, bounds frames in flight and reports busy/done/error status.
module fft_frame_ctrl
  import fft_pkg::*;
(
  input  logic     clk,
  input  logic     rstn,
  input  logic     start,
  input  logic     cont_mode,
  input  logic     stop,
  input  logic     src_valid,
  output logic     src_ready,
  output logic     fft_din_valid,
  output blk_idx_t in_blk_idx,
  input  logic     pipe_out_valid,
  output blk_idx_t out_blk_idx,
  output logic     out_sof,
  output logic     out_eof,
  output logic     frame_done,
  output logic     busy,
  output logic     err_unexp
);

  frame_state_e state;
  inflight_t    inflight;
  inflight_t    inflight_next;
  logic         cont_lat;
  logic         stop_pend;
  logic         accept;
  logic         frame_start;
  logic         last_accept;
  logic         inflight_zero;
  logic         eof_pulse;

  // A new frame may not open while the pipeline already holds the maximum.
  assign src_ready     = (state == FEED) &&
                         !((in_blk_idx == blk_idx_t'(0)) && (inflight == INFLIGHT_MAX));
  assign fft_din_valid = src_valid && src_ready;
  assign accept        = fft_din_valid;
  assign frame_start   = accept && (in_blk_idx == blk_idx_t'(0));
  assign last_accept   = accept && (in_blk_idx == LAST_BLK);
  assign inflight_zero = (inflight == inflight_t'(0));
  assign busy          = (state != IDLE) || !inflight_zero;

  fft_out_tracker u_out_tracker (
    .clk            (clk),
    .rstn           (rstn),
    .pipe_out_valid (pipe_out_valid),
    .inflight_zero  (inflight_zero),
    .out_blk_idx    (out_blk_idx),
    .out_sof        (out_sof),
    .out_eof        (out_eof),
    .eof_pulse      (eof_pulse),
    .frame_done     (frame_done)
  );

  // A frame start and a frame retirement in the same cycle cancel out.
  always_comb begin
    inflight_next = inflight;
    if (frame_start && !eof_pulse && (inflight != INFLIGHT_MAX)) begin
      inflight_next = inflight_t'(inflight + 1'b1);
    end else if (!frame_start && eof_pulse) begin
      inflight_next = inflight_t'(inflight - 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_blk_idx <= '0;
      inflight   <= '0;
      err_unexp  <= 1'b0;
    end else begin
      if (accept) begin
        in_blk_idx <= next_idx(in_blk_idx);
      end
      inflight <= inflight_next;
      if (pipe_out_valid && inflight_zero) begin
        err_unexp <= 1'b1;
      end
    end
  end

  // A stop arriving with the last block still ends the stream after this frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cont_lat  <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= FEED;
            cont_lat  <= cont_mode;
            stop_pend <= 1'b0;
          end
        end
        FEED: begin
          if (stop) begin
            stop_pend <= 1'b1;
          end
          if (last_accept && (!cont_lat || stop_pend || stop)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (inflight_next == inflight_t'(0)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed self-checking bench for fft_frame_ctrl: single, continuous, stop,
// gapped, spurious-return and mid-frame reset scenarios.
module tb_fft_frame_ctrl;

  logic       clk;
  logic       rstn;
  logic       start;
  logic       cont_mode;
  logic       stop;
  logic       src_valid;
  logic       src_ready;
  logic       fft_din_valid;
  logic [4:0] in_blk_idx;
  logic       pipe_out_valid;
  logic [4:0] out_blk_idx;
  logic       out_sof;
  logic       out_eof;
  logic       frame_done;
  logic       busy;
  logic       err_unexp;

  int tests = 0;
  int fails = 0;
  int acc;
  int done_cnt;

  fft_frame_ctrl dut (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .cont_mode      (cont_mode),
    .stop           (stop),
    .src_valid      (src_valid),
    .src_ready      (src_ready),
    .fft_din_valid  (fft_din_valid),
    .in_blk_idx     (in_blk_idx),
    .pipe_out_valid (pipe_out_valid),
    .out_blk_idx    (out_blk_idx),
    .out_sof        (out_sof),
    .out_eof        (out_eof),
    .frame_done     (frame_done),
    .busy           (busy),
    .err_unexp      (err_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge; inputs are changed here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #3;
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; cont_mode = 1'b0; stop = 1'b0;
    src_valid = 1'b1; pipe_out_valid = 1'b0;
    #2;
    check("rst_src_ready", src_ready, 0);
    check("rst_din_valid", fft_din_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_idx", in_blk_idx, 0);
    check("rst_out_idx", out_blk_idx, 0);
    check("rst_err", err_unexp, 0);
    check("rst_frame_done", frame_done, 0);
    rstn = 1'b1;
    src_valid = 1'b0;
    step();

    // Spurious return while idle
    pipe_out_valid = 1'b1;
    #1;
    step();
    pipe_out_valid = 1'b0;
    #1;
    check("unexp_err_set", err_unexp, 1);
    check("unexp_out_idx", out_blk_idx, 0);
    check("unexp_busy", busy, 0);
    step();
    check("unexp_err_sticky", err_unexp, 1);

    // Single frame
    start = 1'b1; cont_mode = 1'b0; src_valid = 1'b1;
    #1;
    check("single_idle_ready", src_ready, 0);
    step();
    start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      check("single_din_valid", fft_din_valid, 1);
      check("single_in_idx", in_blk_idx, i);
      step();
    end
    #1;
    check("single_drain_ready", src_ready, 0);
    check("single_drain_din", fft_din_valid, 0);
    check("single_drain_busy", busy, 1);
    check("single_in_wrap", in_blk_idx, 0);
    src_valid = 1'b0; pipe_out_valid = 1'b1;
    for (int j = 0; j < 32; j++) begin
      #1;
      check("single_out_idx", out_blk_idx, j);
      check("single_sof", out_sof, (j == 0) ? 1 : 0);
      check("single_eof", out_eof, (j == 31) ? 1 : 0);
      check("single_fd_low", frame_done, 0);
      step();
    end
    pipe_out_valid = 1'b0;
    #1;
    check("single_frame_done", frame_done, 1);
    check("single_out_wrap", out_blk_idx, 0);
    step();
    check("single_fd_pulse", frame_done, 0);
    check("single_busy_off", busy, 0);

    // Continuous mode hits the in-flight limit
    start = 1'b1; cont_mode = 1'b1; src_valid = 1'b1;
    step();
    start = 1'b0;
    acc = 0;
    for (int k = 0; k < 80; k++) begin
      #1;
      if (fft_din_valid) acc++;
      step();
    end
    check("cont_accepts", acc, 64);
    check("cont_ready_blocked", src_ready, 0);
    check("cont_in_idx", in_blk_idx, 0);
    pipe_out_valid = 1'b1;
    for (int j = 0; j < 32; j++) begin
      #1;
      if (j == 31) begin
        check("cont_eof", out_eof, 1);
        check("cont_ready_at_eof", src_ready, 0);
      end
      step();
    end
    pipe_out_valid = 1'b0;
    #1;
    check("cont_ready_back", src_ready, 1);
    check("cont_din_back", fft_din_valid, 1);
    do_reset();
    step();

    // Stop during the second frame
    start = 1'b1; cont_mode = 1'b1; src_valid = 1'b1;
    step();
    start = 1'b0;
    acc = 0;
    for (int k = 0; k < 100; k++) begin
      stop = (k == 40);
      #1;
      if (fft_din_valid) acc++;
      step();
    end
    stop = 1'b0;
    #1;
    check("stop_accepts", acc, 64);
    check("stop_ready", src_ready, 0);
    check("stop_busy", busy, 1);
    done_cnt = 0;
    for (int k = 0; k < 70; k++) begin
      pipe_out_valid = (k < 64);
      #1;
      if (frame_done) done_cnt++;
      step();
    end
    pipe_out_valid = 1'b0;
    #1;
    check("stop_done_pulses", done_cnt, 2);
    check("stop_busy_off", busy, 0);
    check("stop_no_err", err_unexp, 0);

    // Gapped input
    start = 1'b1; cont_mode = 1'b0; src_valid = 1'b0;
    step();
    start = 1'b0;
    acc = 0;
    for (int k = 0; k < 80; k++) begin
      src_valid = ((k % 2) == 0);
      #1;
      if (k < 64) check("gap_mirror", fft_din_valid, src_valid);
      if (fft_din_valid) begin
        check("gap_in_idx", in_blk_idx, acc);
        acc++;
      end
      step();
    end
    check("gap_accepts", acc, 32);
    src_valid = 1'b0;

    // Set the error flag again, then reset mid-frame
    do_reset();
    pipe_out_valid = 1'b1;
    step();
    pipe_out_valid = 1'b0;
    #1;
    check("mid_err_pre", err_unexp, 1);
    start = 1'b1; cont_mode = 1'b0; src_valid = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 17; i++) step();
    check("mid_in_idx", in_blk_idx, 17);
    check("mid_busy", busy, 1);
    #1;
    rstn = 1'b0;
    #1;
    check("mid_rst_in_idx", in_blk_idx, 0);
    check("mid_rst_ready", src_ready, 0);
    check("mid_rst_din", fft_din_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", err_unexp, 0);
    check("mid_rst_out_idx", out_blk_idx, 0);
    rstn = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    #1;
    check("restart_in_idx", in_blk_idx, 0);
    check("restart_din", fft_din_valid, 1);
    for (int i = 0; i < 32; i++) step();
    src_valid = 1'b0; pipe_out_valid = 1'b1;
    for (int j = 0; j < 32; j++) step();
    pipe_out_valid = 1'b0;
    #1;
    check("restart_done", frame_done, 1);
    check("restart_busy_off", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
- Frame sequencer for the 16-lane, 512-point FFT pipeline (module_00 → module_01 → module_02 → CBFP).
- Gates upstream 16-sample blocks into the pipeline as frames of 32 blocks and generates the pipeline's din_valid.
- Tracks frames in flight using the pipeline's returned CBFP_valid, and tags returning blocks with index and frame start/end for the CBFP stage.
- Produces busy, frame-done and error status for the top-level controller.

Parameters:
- N_POINT, 512, FFT size in samples.
- LANES, 16, samples per block (per din_valid cycle).
- BLK_PER_FRAME, N_POINT/LANES = 32, blocks per frame.
- MAX_INFLIGHT, 2, maximum frames started but not yet fully returned from the pipeline.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; asynchronous, active-low.
- start  in  1  pulse; arms one frame (single mode) or a frame stream (cont mode).
- cont_mode  in  1  1 = keep accepting frames back-to-back until stop; sampled only in IDLE.
- stop  in  1  pulse; ends cont mode after the current input frame completes.
- src_valid  in  1  upstream block available on in_i/in_q.
- src_ready  out  1  controller accepts a block this cycle.
- fft_din_valid  out  1  drives the pipeline's din_valid.
- in_blk_idx  out  5  index of the next block to accept (0..31).
- pipe_out_valid  in  1  CBFP_valid returned from module_02.
- out_blk_idx  out  5  index of the returning block.
- out_sof  out  1  returning block is block 0.
- out_eof  out  1  returning block is block 31.
- frame_done  out  1  one-cycle pulse, registered, the cycle after an out_eof.
- busy  out  1  state != IDLE or inflight != 0.
- err_unexp  out  1  sticky; pipe_out_valid seen with inflight == 0.

Behaviour:
- States: IDLE, FEED, DRAIN (enum in package).
- Reset values: state = IDLE; in_blk_idx = 0; out_blk_idx = 0; inflight = 0; frame_done = 0; err_unexp = 0; stop_pend = 0. Consequently src_ready = 0, fft_din_valid = 0, busy = 0.
- Reset mid-operation discards all counters immediately. Blocks still inside the pipeline are not tracked after reset; the pipeline's own reset is expected to clear them.
- src_ready = (state == FEED) && !(in_blk_idx == 0 && inflight == MAX_INFLIGHT). Registered-state function only; no combinational path from src_valid.
- fft_din_valid = src_valid && src_ready, combinational, so it is aligned with the data driven straight into the pipeline. Accept = fft_din_valid.
- Gaps (src_valid = 0) inside a frame are legal: fft_din_valid drops, counters hold.
- On accept: in_blk_idx increments, wrapping 31 → 0. If in_blk_idx == 0 at accept, inflight increments (frame started).
- IDLE → FEED: on start. Latch the cont_mode value; clear stop_pend.
- FEED, last block (idx 31) accepted:
  - single mode, or stop_pend set → DRAIN;
  - otherwise stay in FEED and start a new frame.
- stop sets stop_pend. stop in IDLE is ignored; start while not in IDLE is ignored.
- DRAIN → IDLE: when inflight == 0. This transition may coincide with the decrement cycle.
- Output side, on pipe_out_valid:
  - out_sof/out_eof are combinational: pipe_out_valid && out_blk_idx == 0 / == 31.
  - out_blk_idx increments, wrapping 31 → 0.
  - At out_eof, inflight decrements and frame_done is set next cycle.
- Simultaneous frame start and out_eof in the same cycle: inflight is unchanged (net 0).
- pipe_out_valid with inflight == 0: set err_unexp; counters are not advanced; inflight never underflows.
- inflight width is clog2(MAX_INFLIGHT+1). It saturates and cannot exceed MAX_INFLIGHT because of the src_ready gating.
- Latency: combinational from src_valid to fft_din_valid; frame_done follows out_eof by 1 cycle.

Decomposition:
- Shared package fft_pkg holds N_POINT, LANES, BLK_PER_FRAME, the frame_state_e enum (IDLE, FEED, DRAIN), and the blk_idx_t typedef (logic [4:0]).
- One sub-module, fft_out_tracker: owns out_blk_idx, out_sof, out_eof and the eof pulse. Its eof pulse drives both the inflight decrement and frame_done. The FSM and input counter remain in the top of fft_frame_ctrl.

Test Plan:
- Single frame: cont_mode = 0, start, src_valid held high → 32 fft_din_valid cycles with in_blk_idx 0..31, then DRAIN. Return 32 pipe_out_valid → out_sof on block 0, out_eof on block 31, frame_done 1 cycle later, busy = 0 the following cycle.
- Continuous with limit: cont_mode = 1, src_valid always 1, no pipe_out_valid → exactly 64 accepts, then src_ready = 0 at in_blk_idx 0. One returned frame (32 valids) → src_ready reasserts the cycle after out_eof.
- Stop: stop pulsed during the 2nd frame → that frame completes (64 total accepts), DRAIN, IDLE after 2 returned frames, 2 frame_done pulses.
- Gaps: src_valid toggling 1/0 → fft_din_valid mirrors src_valid, in_blk_idx advances only on accept, frame still exactly 32 accepts.
- Unexpected output: pipe_out_valid in IDLE after reset → err_unexp = 1 and sticky; out_blk_idx stays 0.
- Reset mid-frame: rstn low at in_blk_idx = 17 with inflight = 1 → all outputs at reset values asynchronously. A new start then begins at in_blk_idx 0 with inflight 0 → 1.
